// File: rtl/jk_seq_pkg.sv
// Shared types for the JK command sequencer: op encodings, FSM states and
// the JK next-state function used by the reference model.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // JK flip-flop transfer: 00 hold, 01 clear, 10 set, 11 invert
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers and a separate occupancy
// counter for full/empty.
// Ports:
//   clk, rstn     - clock, synchronous active-high reset
//   push, wdata   - write request and payload (ignored when full)
//   pop           - read request (ignored when empty)
//   rdata_c       - head entry, combinational read of the storage array
//   full, empty   - registered occupancy flags
//   can_push      - registered !full, held low while in reset
//   empty_nxt_c   - occupancy-is-zero after the current edge
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty,
    output logic             can_push,
    output logic             empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             can_push_q, can_push_d;
    logic             push_ok, pop_ok;

    // Pointer/occupancy update; simultaneous push+pop leaves count unchanged
    always_comb begin
        push_ok    = push && !full_q;
        pop_ok     = pop && !empty_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == CW'(0));
        can_push_d = !full_d;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            can_push_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            can_push_q <= can_push_d;
        end
    end

    // Storage needs no reset; validity is tracked by the occupancy counter
    always_ff @(posedge clk) begin
        if (push_ok && !rstn) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata_c     = mem_q[rd_ptr_q];
    assign full        = full_q;
    assign empty       = empty_q;
    assign can_push    = can_push_q;
    assign empty_nxt_c = empty_d;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command-driven J/K stimulus generator with an on-board JK reference model
// and mismatch checker on the returned Q.
// Ports:
//   clk, rstn             - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (ready = FIFO not full)
//   cmd_op, cmd_dur       - op (HOLD/RESET/SET/TOGGLE) and cycle count (0 acts as 1)
//   J, K                  - registered drive to the flip-flop
//   Q                     - flip-flop output under check
//   busy                  - running a command or commands queued
//   err, err_cnt          - sticky mismatch flag and saturating mismatch count
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DUR_W = 8,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DUR_W-1:0] cmd_dur,
    output logic             J,
    output logic             K,
    input  logic             Q,
    output logic             busy,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned WIDTH = 2 + DUR_W;

    seq_state_e       state_q, state_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             q_model_q, q_model_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       settle_q, settle_d;

    logic             push_c, pop_c, load_c;
    logic             fifo_empty, fifo_full, fifo_can_push, fifo_empty_nxt_c;
    logic [WIDTH-1:0] head_c;
    jk_op_e           head_op;
    logic [DUR_W-1:0] head_dur;

    assign push_c   = cmd_valid && fifo_can_push;
    assign head_op  = jk_op_e'(head_c[WIDTH-1 -: 2]);
    assign head_dur = head_c[DUR_W-1:0];

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push        (push_c),
        .wdata       ({cmd_op, cmd_dur}),
        .pop         (pop_c),
        .rdata_c     (head_c),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .can_push    (fifo_can_push),
        .empty_nxt_c (fifo_empty_nxt_c)
    );

    // Sequencer FSM: load from FIFO head with no gap between commands
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) load_c = 1'b1;
            end
            RUN: begin
                if (cnt_q != DUR_W'(0)) begin
                    cnt_d = cnt_q - DUR_W'(1);
                end else if (!fifo_empty) begin
                    load_c = 1'b1;
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_c) begin
            pop_c   = 1'b1;
            j_d     = head_op[1];
            k_d     = head_op[0];
            // cnt counts remaining cycles after this one; dur 0 behaves as 1
            cnt_d   = (head_dur == DUR_W'(0)) ? DUR_W'(0) : head_dur - DUR_W'(1);
            state_d = RUN;
        end
        busy_d = (state_d == RUN) || !fifo_empty_nxt_c;
    end

    // Reference model and checker; compare uses the pre-update model value
    always_comb begin
        q_model_d = jk_next(q_model_q, j_q, k_q);
        settle_d  = settle_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
        if (settle_q == 2'd2 && Q != q_model_q) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            q_model_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            settle_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            q_model_q <= q_model_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            settle_q  <= settle_d;
        end
    end

    assign cmd_ready = fifo_can_push && !fifo_full;
    assign J         = j_q;
    assign K         = k_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop
// (optionally stuck at 0) closing the loop on Q.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_dur;
    logic       J, K, Q;
    logic       busy, err;
    logic [7:0] err_cnt;

    logic       q_ff;
    logic       fault;
    logic       rec_en;
    logic [1:0] trace [$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;

    jk_cmd_sequencer #(.DEPTH(4), .DUR_W(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dur   (cmd_dur),
        .J         (J),
        .K         (K),
        .Q         (Q),
        .busy      (busy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic ff_next(input logic q, input logic j, input logic k);
        if (!j && !k) return q;
        if (!j && k)  return 1'b0;
        if (j && !k)  return 1'b1;
        return ~q;
    endfunction

    always @(posedge clk) begin
        if (rstn) q_ff <= 1'b0;
        else      q_ff <= ff_next(q_ff, J, K);
    end
    assign Q = fault ? 1'b0 : q_ff;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rec_en) trace.push_back({J, K});
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] ops6 [6];
    logic       any_active;

    initial begin
        ops6[0] = 2'b10; ops6[1] = 2'b11; ops6[2] = 2'b01;
        ops6[3] = 2'b10; ops6[4] = 2'b11; ops6[5] = 2'b01;
        rstn = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dur = 8'd0;
        fault = 1'b0; rec_en = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_j", 32'(J), 0);
        chk("rst_k", 32'(K), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        rstn = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Idle for 50 cycles
        any_active = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (J || K || busy) any_active = 1'b1;
        end
        chk("idle_quiet", 32'(any_active), 0);
        chk("idle_err", 32'(err), 0);

        // Single SET dur=3
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dur = 8'd3;
        tick();
        cmd_valid = 1'b0;
        chk("set_accept_jk", 32'({J, K}), 0);
        chk("set_accept_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("set_jk_%0d", i), 32'({J, K}), 32'b10);
        end
        tick();
        chk("set_end_jk", 32'({J, K}), 0);
        chk("set_end_busy", 32'(busy), 0);
        chk("set_q", 32'(Q), 1);
        chk("set_err", 32'(err), 0);

        // Back-to-back SET1, TOGGLE2, RESET1, HOLD0
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dur = 8'd1;
        tick();
        cmd_op = 2'b11; cmd_dur = 8'd2;
        tick();
        chk("b2b_jk0", 32'({J, K}), 32'b10);
        cmd_op = 2'b01; cmd_dur = 8'd1;
        tick();
        chk("b2b_jk1", 32'({J, K}), 32'b11);
        chk("b2b_q0", 32'(Q), 1);
        cmd_op = 2'b00; cmd_dur = 8'd0;
        tick();
        cmd_valid = 1'b0;
        chk("b2b_jk2", 32'({J, K}), 32'b11);
        chk("b2b_q1", 32'(Q), 0);
        tick();
        chk("b2b_jk3", 32'({J, K}), 32'b01);
        chk("b2b_q2", 32'(Q), 1);
        tick();
        chk("b2b_jk4", 32'({J, K}), 32'b00);
        chk("b2b_q3", 32'(Q), 0);
        tick();
        chk("b2b_jk5", 32'({J, K}), 32'b00);
        chk("b2b_q4", 32'(Q), 0);
        chk("b2b_busy", 32'(busy), 0);
        chk("b2b_err", 32'(err), 0);

        // Six dur=5 commands with cmd_valid held: backpressure and ordering
        cmd_valid = 1'b1; cmd_dur = 8'd5;
        cmd_op = ops6[0];
        chk("bp_ready0", 32'(cmd_ready), 1);
        tick();
        rec_en = 1'b1;
        for (int i = 1; i < 5; i++) begin
            cmd_op = ops6[i];
            tick();
        end
        chk("bp_full_ready", 32'(cmd_ready), 0);
        cmd_op = ops6[5];
        tick();
        chk("bp_still_full", 32'(cmd_ready), 0);
        tick();
        chk("bp_ready_after_pop", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_full_again", 32'(cmd_ready), 0);
        repeat (25) tick();
        rec_en = 1'b0;
        chk("bp_trace_len", 32'(trace.size()), 32);
        for (int i = 0; i < 32; i++) begin
            if (i < trace.size())
                chk($sformatf("bp_trace_%0d", i), 32'(trace[i]), (i < 30) ? 32'(ops6[i / 5]) : 32'd0);
        end
        chk("bp_busy", 32'(busy), 0);
        chk("bp_err", 32'(err), 0);

        // Stuck-at-0 flip-flop with SET dur=4
        fault = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dur = 8'd4;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("flt_err_early", 32'(err), 0);
        repeat (4) tick();
        chk("flt_err", 32'(err), 1);
        chk("flt_err_cnt4", 32'(err_cnt), 4);
        repeat (300) tick();
        chk("flt_err_cnt_sat", 32'(err_cnt), 255);
        chk("flt_err_sticky", 32'(err), 1);

        // Reset during second cycle of TOGGLE dur=10 with two queued
        fault = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_dur = 8'd10;
        tick();
        cmd_op = 2'b10; cmd_dur = 8'd1;
        tick();
        chk("mid_toggle_jk", 32'({J, K}), 32'b11);
        cmd_op = 2'b01; cmd_dur = 8'd1;
        tick();
        cmd_valid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("mid_rst_jk", 32'({J, K}), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        rstn = 1'b0;
        any_active = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (J || K || busy) any_active = 1'b1;
        end
        chk("post_rst_quiet", 32'(any_active), 0);
        chk("post_rst_err", 32'(err), 0);
        chk("post_rst_ready", 32'(cmd_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
